// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master.
package apb_pkg;

    localparam int DEF_ADDRW = 32;
    localparam int DEF_DATAW = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

endpackage

// File: rtl/apb_master_wdog.sv
// ACCESS wait-state watchdog: flags the TIMEOUT-th consecutive PREADY=0 cycle.
// Instantiated by apb_master only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic wait_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = wait_i && (cnt_q == CW'(TIMEOUT - 1));

    // NOTE: always_comb assigns a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, one APB transfer, response out.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDRW   = DEF_ADDRW,
    parameter int DATAW   = DEF_DATAW,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [ADDRW-1:0] cmd_addr,
    input  logic [DATAW-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [ADDRW-1:0] PADDR,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [DATAW-1:0] PWDATA,
    input  logic             PREADY,
    input  logic [DATAW-1:0] PRDATA,
    input  logic             PSLVERR
);

    apb_state_e       state_q;
    logic [ADDRW-1:0] paddr_q;
    logic [DATAW-1:0] pwdata_q;
    logic             pwrite_q;
    logic             psel_q;
    logic             penable_q;
    logic             rsp_valid_q;
    logic [DATAW-1:0] rsp_rdata_q;
    logic             rsp_err_q;
    logic             wdog_expired;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clear_i   (state_q == ST_SETUP),
        .wait_i    ((state_q == ST_ACCESS) && !PREADY),
        .expired_o (wdog_expired)
    );
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
    assign wdog_expired   = 1'b0;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        paddr_q  <= cmd_addr;
                        pwrite_q <= cmd_write;
                        pwdata_q <= cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Slave inputs are only looked at here; address/data stay frozen.
                    if (PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= PSLVERR;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        state_q     <= ST_RESP;
                    end else if (wdog_expired) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; outputs sampled on the falling edge.
// Timeout scenario runs only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int n_pass  = 0;
    int n_total = 0;

    apb_master #(
        .ADDRW   (32),
        .DATAW   (32),
        .TIMEOUT (16)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        @(negedge PCLK);
        tick();
        tick();

        // Reset state
        check("rst_psel",      PSEL, 0);
        check("rst_penable",   PENABLE, 0);
        check("rst_pwrite",    PWRITE, 0);
        check("rst_paddr",     PADDR, 0);
        check("rst_pwdata",    PWDATA, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err, 0);
        PRESET = 1'b0;
        tick();
        check("rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write, addr 100 data 200
        PREADY    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'd100;
        cmd_wdata = 32'd200;
        check("wr_accept_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("wr_setup_psel",    PSEL, 1);
        check("wr_setup_penable", PENABLE, 0);
        check("wr_setup_paddr",   PADDR, 100);
        check("wr_setup_pwdata",  PWDATA, 200);
        check("wr_setup_pwrite",  PWRITE, 1);
        check("wr_setup_cmd_rdy", cmd_ready, 0);
        tick();
        check("wr_access_psel",    PSEL, 1);
        check("wr_access_penable", PENABLE, 1);
        check("wr_access_rsp_vld", rsp_valid, 0);
        tick();
        check("wr_resp_psel",    PSEL, 0);
        check("wr_resp_penable", PENABLE, 0);
        check("wr_resp_valid",   rsp_valid, 1);
        check("wr_resp_err",     rsp_err, 0);
        check("wr_resp_rdata",   rsp_rdata, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("wr_idle_valid",  rsp_valid, 0);
        check("wr_idle_ready",  cmd_ready, 1);
        check("wr_idle_paddr",  PADDR, 100);

        // Zero-wait read, slave returns 200; handshake overlaps a new command
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'd100;
        PRDATA    = 32'd200;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rd_resp_valid", rsp_valid, 1);
        check("rd_resp_rdata", rsp_rdata, 200);
        check("rd_resp_err",   rsp_err, 0);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = 32'h44;
        PRDATA    = 32'h55;
        check("bubble_cmd_ready_resp", cmd_ready, 0);
        tick();
        rsp_ready = 1'b0;
        check("bubble_idle_ready", cmd_ready, 1);
        check("bubble_idle_psel",  PSEL, 0);
        check("bubble_rsp_valid",  rsp_valid, 0);

        // Read with three wait states; PREADY/PSLVERR high in SETUP must be ignored
        tick();
        cmd_valid = 1'b0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b1;
        check("ws_setup_psel",    PSEL, 1);
        check("ws_setup_penable", PENABLE, 0);
        check("ws_setup_paddr",   PADDR, 32'h44);
        tick();
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ws_wait%0d_penable", i), PENABLE, 1);
            check($sformatf("ws_wait%0d_paddr", i),   PADDR, 32'h44);
            check($sformatf("ws_wait%0d_rsp_vld", i), rsp_valid, 0);
            tick();
        end
        PREADY = 1'b1;
        PRDATA = 32'h1234;
        check("ws_last_penable", PENABLE, 1);
        check("ws_last_paddr",   PADDR, 32'h44);
        tick();
        check("ws_resp_valid",   rsp_valid, 1);
        check("ws_resp_rdata",   rsp_rdata, 32'h1234);
        check("ws_resp_err",     rsp_err, 0);
        check("ws_resp_penable", PENABLE, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Write completing with PSLVERR, response back-pressured 5 cycles
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h8;
        cmd_wdata = 32'hAB;
        PSLVERR   = 1'b1;
        tick();
        tick();
        tick();
        PSLVERR = 1'b0;
        check("err_resp_valid", rsp_valid, 1);
        check("err_resp_err",   rsp_err, 1);
        check("err_resp_rdata", rsp_rdata, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("err_hold%0d_valid", i), rsp_valid, 1);
            check($sformatf("err_hold%0d_err", i),   rsp_err, 1);
            check($sformatf("err_hold%0d_ready", i), cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("err_idle_valid", rsp_valid, 0);

        // Reset asserted during ACCESS aborts with no response
        PREADY    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("abort_access_penable", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        check("abort_psel",      PSEL, 0);
        check("abort_penable",   PENABLE, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        PRESET = 1'b0;
        tick();
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_no_resp",   rsp_valid, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        // PREADY stuck low: abort on the 16th wait cycle
        cmd_valid = 1'b1;
        cmd_addr  = 32'h30;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("to_still_penable", PENABLE, 1);
        check("to_still_no_resp", rsp_valid, 0);
        tick();
        check("to_resp_valid", rsp_valid, 1);
        check("to_resp_err",   rsp_err, 1);
        check("to_resp_rdata", rsp_rdata, 0);
        check("to_resp_psel",  PSEL, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
